uart_tx: RTL

Serial UART transmitter, the transmit half of the team's UART link. Accepts parallel words on a valid/ready handshake, buffers one word, and shifts each out as start bit, WIDTH data bits LSB first, odd parity bit, and stop bit. Runs on a 16x oversampled clock, so one bit period is 16 clocks, matching the receiver's sampling. Sits between the host-side data source and the serial pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_baud.sv | 29 ++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   state_t     : transmitter FSM states (PARITY only when UART_TX_PARITY_EN is defined)
//   OVERSAMPLE  : clocks per bit period (16x oversampled clock)
//   OS_CNT_W    : width of the oversample counter
//   odd_parity  : parity bit that makes the total count of ones (data + parity) odd
// Configuration macro: UART_TX_PARITY_EN
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int OS_CNT_W   = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   // Zero-extension to 32 bits does not change the XOR reduction, so any
   // word up to 32 bits can be passed in.
   function automatic logic odd_parity(input logic [31:0] word);
      return ~^word;
   endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// uart_tx_baud -- oversample counter for the UART transmitter.
//   tx_clk   : 16x baud clock
//   tx_reset : asynchronous, active-low reset
//   clr      : synchronous clear, counter returns to 0 on the next edge
//   bit_end  : high on the last clock of a bit period (counter == 15)
module uart_tx_baud
   import uart_pkg::*;
(
   input  logic tx_clk,
   input  logic tx_reset,
   input  logic clr,
   output logic bit_end
);

   logic [OS_CNT_W-1:0] cnt_reg;

   always_ff @(posedge tx_clk or negedge tx_reset) begin
      if (!tx_reset) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;   // wraps 15 -> 0
      end
   end

   assign bit_end = (cnt_reg == OS_CNT_W'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter with a one-word holding buffer.
// Frame: start (0), WIDTH data bits LSB first, [odd parity], stop (1);
// each bit lasts 16 clocks of the oversampled clock.
//   tx_clk   : 16x baud clock, rising edge
//   tx_reset : asynchronous, active-low reset
//   tx_valid : data_in holds a word to send
//   data_in  : word to transmit
//   tx_ready : holding buffer empty; word accepted on tx_valid && tx_ready
//   tx       : registered serial output, idle high
//   busy     : a frame is being shifted out
//   done     : one-cycle pulse on the cycle after the stop bit's last clock
// Configuration macro: UART_TX_PARITY_EN (defined -> parity bit in frame)
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             tx_clk,
   input  logic             tx_reset,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic             tx_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

   state_t               state_reg,   state_next;
   logic [WIDTH-1:0]     buf_reg,     buf_next;
   logic                 full_reg,    full_next;
   logic [WIDTH-1:0]     shift_reg,   shift_next;
   logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic                 tx_reg,      tx_next;
   logic                 done_reg,    done_next;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg,  parity_next;
`endif

   logic accept;
   logic load;
   logic bit_end;

   // Acceptance needs an empty buffer and a load needs a full one, so the
   // two can never happen on the same edge.
   assign accept = tx_valid && !full_reg;
   // The shifter takes the buffered word from IDLE, or straight at the end
   // of a stop bit so consecutive frames run without an idle gap.
   assign load   = full_reg && ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

   uart_tx_baud u_baud (
      .tx_clk   (tx_clk),
      .tx_reset (tx_reset),
      .clr      ((state_reg == IDLE) || load),
      .bit_end  (bit_end)
   );

   always_ff @(posedge tx_clk or negedge tx_reset) begin
      if (!tx_reset) begin
         state_reg   <= IDLE;
         buf_reg     <= '0;
         full_reg    <= 1'b0;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= 1'b1;
         done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         buf_reg     <= buf_next;
         full_reg    <= full_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         tx_reg      <= tx_next;
         done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      buf_next     = buf_reg;
      full_next    = full_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      done_next    = 1'b0;
      tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_next  = parity_reg;
`endif

      if (accept) begin
         buf_next  = data_in;
         full_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (full_reg) state_next = START;
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  shift_next   = shift_reg >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               done_next  = 1'b1;
               state_next = full_reg ? START : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (load) begin
         shift_next = buf_reg;
         full_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_next = odd_parity(32'(buf_reg));
`endif
      end

      // tx is registered, so it is driven from the state being entered.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_reg;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   assign tx_ready = ~full_reg;
   assign tx       = tx_reg;
   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;

endmodule
